execute_mem_dcache_tag_ctrl: RTL and testbench
==============================================

EXECUTE_MEM_DCACHE_TAG_CTRL -- requirements
Module: execute_mem_dcache_tag_ctrl

Interface
REQ-001 Parameters: IDX_W, default 8, tag array index width; TAG_W, default 19, tag width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports are clk and resetn.
REQ-003 clk  in  1  clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 refill_req  in  1  refill tag-write request, level, held until ack.
REQ-006 refill_addr  in  IDX_W  refill index; refill_tag  in  TAG_W  refill tag.
REQ-007 refill_ack  out  1  one-cycle pulse, refill written.
REQ-008 inv_req  in  1  conditional-invalidate request, level, held until ack.
REQ-009 inv_addr  in  IDX_W  index; inv_tag  in  TAG_W  tag to match.
REQ-010 inv_ack  out  1  pulse, invalidate done; inv_hit  out  1  valid with inv_ack, entry matched and was cleared.
REQ-011 flush_req  in  1  flush-all request, level; flush_busy  out  1  sweep active; flush_done  out  1  pulse after last index.
REQ-012 wea  out  1; addra  out  IDX_W; dina_valid  out  1; dina_tag  out  TAG_W  tag array write port, all registered.
REQ-013 addrc  out  IDX_W  tag read port 1 address, registered; doutc_valid  in  1; doutc_tag  in  TAG_W  combinational read data.

Function
REQ-014 FSM states SHALL be IDLE, INV_CMP, FLUSH; only IDLE accepts requests.
REQ-015 Priority in IDLE: flush_req > inv_req > refill_req; one request accepted per cycle.
REQ-016 Refill: accepted in IDLE -> next cycle wea=1, addra=refill_addr, dina_valid=1, dina_tag=refill_tag, refill_ack=1, state stays IDLE; latency 1 cycle.
REQ-017 No request SHALL be accepted in a cycle where that requester's ack is high, so a held req is never serviced twice.
REQ-018 Invalidate: accepted in IDLE -> addrc<=inv_addr, go INV_CMP.
REQ-019 In INV_CMP: hit = doutc_valid && (doutc_tag == inv_tag). Next cycle: inv_ack=1, inv_hit=hit, wea=hit, addra=addrc, dina_valid=0, dina_tag=inv_tag. Return to IDLE. Total latency 2 cycles.
REQ-020 Flush: accepted in IDLE -> counter<=0, flush_busy=1, go FLUSH.
REQ-021 In FLUSH, each cycle wea=1, addra=counter, dina_valid=0, dina_tag=0; counter increments with 8-bit wrap.
REQ-022 When counter reaches 255, the controller SHALL do the following in the cycle after the write to 255: flush_done=1 and flush_busy=0, then return to IDLE. The sweep takes exactly 256 write cycles.
REQ-023 Requests arriving in INV_CMP or FLUSH SHALL be held off with no ack, and served on return to IDLE by priority.
REQ-024 flush_req still high in the flush_done cycle SHALL NOT restart the sweep. The requester drops it that cycle; if it is high the following cycle, a new sweep starts.
REQ-025 wea SHALL be 0 in every cycle not listed in REQ-016/019/021; at most one write per cycle.

Reset
REQ-026 On resetn low, the following SHALL be cleared asynchronously: state to IDLE, counter to 0, and all outputs (wea, addra, dina_*, addrc, acks, inv_hit, flush_busy, flush_done) to 0.
REQ-027 Reset mid-flush or mid-invalidate SHALL abort the operation and raise no ack or done. A held request is re-served after reset release.

Structure
REQ-028 IDX_W, TAG_W, and the state encoding (2-bit: IDLE=0, INV_CMP=1, FLUSH=2) SHALL reside in the shared dcache package.
REQ-029 The block SHALL be a single module with no sub-modules. The parent connects it to the tag array write port and read port 1.

Verification
REQ-030 Refill addr=0x12 tag=0x5A5A5, then read back -> cycle+1: wea=1, addra=0x12, dina_valid=1, refill_ack=1; readback valid=1, tag=0x5A5A5.
REQ-031 Invalidate addr=0x12 tag=0x5A5A5 after REQ-030 -> cycle+2: inv_ack=1, inv_hit=1, wea=1, dina_valid=0. The same request with tag=0x00001 -> inv_hit=0, wea=0.
REQ-032 flush_req pulse from IDLE -> 256 consecutive wea cycles with addra 0..255. Then flush_done=1 one cycle after addra=255, and all valids read 0.
REQ-033 flush_req, inv_req and refill_req raised together -> flush completes first, then inv_ack, then refill_ack 1 cycle later; no overlapping wea.
REQ-034 resetn low at flush index 100 -> outputs 0 immediately, no flush_done. After release with flush_req low, state IDLE and wea=0.

Source files
------------

// File: rtl/execute_mem_dcache_tag_ctrl_pkg.sv
// Shared dcache definitions: default tag-array geometry and the
// tag-controller state encoding.
package execute_mem_dcache_tag_ctrl_pkg;

   localparam int DCACHE_IDX_W = 8;
   localparam int DCACHE_TAG_W = 19;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_INV_CMP = 2'd1,
      ST_FLUSH   = 2'd2
   } tag_ctrl_state_t;

endpackage

// File: rtl/execute_mem_dcache_tag_ctrl.sv
// Dcache tag-array controller: serialises refill writes, conditional
// invalidates (read-compare-clear via read port 1) and a full flush sweep
// onto the single tag-array write port.
module execute_mem_dcache_tag_ctrl
   import execute_mem_dcache_tag_ctrl_pkg::*;
#(
   parameter int IDX_W = DCACHE_IDX_W,
   parameter int TAG_W = DCACHE_TAG_W
) (
   input  logic             clk,
   input  logic             resetn,

   input  logic             refill_req,
   input  logic [IDX_W-1:0] refill_addr,
   input  logic [TAG_W-1:0] refill_tag,
   output logic             refill_ack,

   input  logic             inv_req,
   input  logic [IDX_W-1:0] inv_addr,
   input  logic [TAG_W-1:0] inv_tag,
   output logic             inv_ack,
   output logic             inv_hit,

   input  logic             flush_req,
   output logic             flush_busy,
   output logic             flush_done,

   output logic             wea,
   output logic [IDX_W-1:0] addra,
   output logic             dina_valid,
   output logic [TAG_W-1:0] dina_tag,

   output logic [IDX_W-1:0] addrc,
   input  logic             doutc_valid,
   input  logic [TAG_W-1:0] doutc_tag
);

   tag_ctrl_state_t  state;
   logic [IDX_W-1:0] counter;

   logic inv_match;
   logic flush_ok;
   logic inv_ok;
   logic refill_ok;

   // Tag compare on the combinational read data of the entry addressed by addrc.
   assign inv_match = doutc_valid && (doutc_tag == inv_tag);

   // A requester whose ack/done is high this cycle is still holding its
   // level request; masking it here keeps one request from being served twice.
   assign flush_ok  = flush_req  && !flush_done;
   assign inv_ok    = inv_req    && !inv_ack;
   assign refill_ok = refill_req && !refill_ack;

   // Controller FSM with all outputs registered.
   // NOTE: every register here uses <= so all of them update together from
   // the values sampled at the same clock edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         counter    <= '0;
         wea        <= 1'b0;
         addra      <= '0;
         dina_valid <= 1'b0;
         dina_tag   <= '0;
         addrc      <= '0;
         refill_ack <= 1'b0;
         inv_ack    <= 1'b0;
         inv_hit    <= 1'b0;
         flush_busy <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low each cycle; only the branch that
         // owns a pulse raises it, so a missed branch cannot leave it stuck.
         wea        <= 1'b0;
         refill_ack <= 1'b0;
         inv_ack    <= 1'b0;
         inv_hit    <= 1'b0;
         flush_done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (flush_busy) begin
                  // Last sweep write has just been presented: close the flush.
                  flush_busy <= 1'b0;
                  flush_done <= 1'b1;
               end else if (flush_ok) begin
                  counter    <= '0;
                  flush_busy <= 1'b1;
                  state      <= ST_FLUSH;
               end else if (inv_ok) begin
                  addrc <= inv_addr;
                  state <= ST_INV_CMP;
               end else if (refill_ok) begin
                  wea        <= 1'b1;
                  addra      <= refill_addr;
                  dina_valid <= 1'b1;
                  dina_tag   <= refill_tag;
                  refill_ack <= 1'b1;
               end
            end

            ST_INV_CMP: begin
               inv_ack    <= 1'b1;
               inv_hit    <= inv_match;
               wea        <= inv_match;
               addra      <= addrc;
               dina_valid <= 1'b0;
               dina_tag   <= inv_tag;
               state      <= ST_IDLE;
            end

            ST_FLUSH: begin
               wea        <= 1'b1;
               addra      <= counter;
               dina_valid <= 1'b0;
               dina_tag   <= '0;
               counter    <= counter + 1'b1;
               if (counter == '1) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_execute_mem_dcache_tag_ctrl.sv
// Self-checking bench for execute_mem_dcache_tag_ctrl: a behavioural tag
// array sits on the write port and read port 1, and a shadow copy of the
// cache contents predicts every invalidate outcome and the final array state.
module tb_execute_mem_dcache_tag_ctrl;

   localparam int IW = 8;
   localparam int TW = 19;
   localparam int N  = 256;

   logic          clk;
   logic          resetn;
   logic          refill_req;
   logic [IW-1:0] refill_addr;
   logic [TW-1:0] refill_tag;
   logic          refill_ack;
   logic          inv_req;
   logic [IW-1:0] inv_addr;
   logic [TW-1:0] inv_tag;
   logic          inv_ack;
   logic          inv_hit;
   logic          flush_req;
   logic          flush_busy;
   logic          flush_done;
   logic          wea;
   logic [IW-1:0] addra;
   logic          dina_valid;
   logic [TW-1:0] dina_tag;
   logic [IW-1:0] addrc;
   logic          doutc_valid;
   logic [TW-1:0] doutc_tag;

   int checks = 0;
   int errors = 0;

   // Tag array as the parent would provide it.
   logic          mem_valid [N];
   logic [TW-1:0] mem_tag   [N];
   logic          mem_clear;

   // Expected cache contents, updated from the operation semantics.
   logic          sh_valid [N];
   logic [TW-1:0] sh_tag   [N];

   execute_mem_dcache_tag_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .refill_req  (refill_req),
      .refill_addr (refill_addr),
      .refill_tag  (refill_tag),
      .refill_ack  (refill_ack),
      .inv_req     (inv_req),
      .inv_addr    (inv_addr),
      .inv_tag     (inv_tag),
      .inv_ack     (inv_ack),
      .inv_hit     (inv_hit),
      .flush_req   (flush_req),
      .flush_busy  (flush_busy),
      .flush_done  (flush_done),
      .wea         (wea),
      .addra       (addra),
      .dina_valid  (dina_valid),
      .dina_tag    (dina_tag),
      .addrc       (addrc),
      .doutc_valid (doutc_valid),
      .doutc_tag   (doutc_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tag array write port.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < N; i++) begin
            mem_valid[i] <= 1'b0;
            mem_tag[i]   <= '0;
         end
      end else if (wea) begin
         mem_valid[addra] <= dina_valid;
         mem_tag[addra]   <= dina_tag;
      end
   end

   // Tag array read port 1, combinational.
   assign doutc_valid = mem_valid[addrc];
   assign doutc_tag   = mem_tag[addrc];

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_compare(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < N; i++) begin
         if (mem_valid[i] !== sh_valid[i]) bad++;
         else if (sh_valid[i] && (mem_tag[i] !== sh_tag[i])) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic do_refill(input logic [IW-1:0] a, input logic [TW-1:0] t, input bit hold_extra);
      int lat;
      refill_addr = a;
      refill_tag  = t;
      refill_req  = 1'b1;
      lat = 0;
      while (!refill_ack && lat < 20) begin
         tick();
         lat++;
      end
      check("refill_latency", lat, 1);
      check("refill_wea", wea, 1);
      check("refill_addra", addra, a);
      check("refill_dina_valid", dina_valid, 1);
      check("refill_dina_tag", dina_tag, t);
      sh_valid[a] = 1'b1;
      sh_tag[a]   = t;
      if (hold_extra) begin
         tick();
         check("refill_no_double_service", {wea, refill_ack}, 0);
      end
      refill_req = 1'b0;
      tick();
      check("refill_wea_idle", wea, 0);
   endtask

   task automatic do_inv(input logic [IW-1:0] a, input logic [TW-1:0] t);
      int   lat;
      logic exp_hit;
      exp_hit  = sh_valid[a] && (sh_tag[a] == t);
      inv_addr = a;
      inv_tag  = t;
      inv_req  = 1'b1;
      lat = 0;
      while (!inv_ack && lat < 20) begin
         tick();
         lat++;
      end
      check("inv_latency", lat, 2);
      check("inv_hit", inv_hit, exp_hit);
      check("inv_wea", wea, exp_hit);
      check("inv_addra", addra, a);
      check("inv_dina_valid", dina_valid, 0);
      if (exp_hit) sh_valid[a] = 1'b0;
      inv_req = 1'b0;
      tick();
      check("inv_idle", {wea, inv_ack}, 0);
   endtask

   task automatic do_flush(input bit hold);
      int bad;
      flush_req = 1'b1;
      tick();
      check("flush_busy_start", flush_busy, 1);
      check("flush_wea_start", wea, 0);
      if (!hold) flush_req = 1'b0;
      bad = 0;
      for (int i = 0; i < N; i++) begin
         tick();
         if (wea !== 1'b1 || addra !== i[IW-1:0] || dina_valid !== 1'b0) bad++;
      end
      check("flush_sweep_writes", bad, 0);
      tick();
      check("flush_done_pulse", flush_done, 1);
      check("flush_busy_end", flush_busy, 0);
      check("flush_wea_end", wea, 0);
      flush_req = 1'b0;
      for (int i = 0; i < N; i++) sh_valid[i] = 1'b0;
      tick();
      check("flush_no_restart", {flush_busy, flush_done, wea}, 0);
   endtask

   initial begin
      int          lat;
      int          cyc;
      int          done_cyc;
      int          inv_cyc;
      int          ref_cyc;
      int          wea_cnt;
      int          seen;
      bit          found;
      logic        inv_hit_seen;
      logic [IW-1:0] a;
      logic [TW-1:0] t;

      resetn      = 1'b0;
      mem_clear   = 1'b1;
      refill_req  = 1'b0;
      refill_addr = '0;
      refill_tag  = '0;
      inv_req     = 1'b0;
      inv_addr    = '0;
      inv_tag     = '0;
      flush_req   = 1'b0;
      for (int i = 0; i < N; i++) begin
         sh_valid[i] = 1'b0;
         sh_tag[i]   = '0;
      end

      // Reset state.
      #1;
      check("reset_outputs",
            {wea, dina_valid, refill_ack, inv_ack, inv_hit, flush_busy, flush_done}, 0);
      check("reset_addra", addra, 0);
      check("reset_addrc", addrc, 0);
      check("reset_dina_tag", dina_tag, 0);
      repeat (3) @(posedge clk);
      #1;
      mem_clear = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // Directed refill and readback, then hit and miss invalidates.
      do_refill(8'h12, 19'h5A5A5, 1'b1);
      check("readback_valid", mem_valid[8'h12], 1);
      check("readback_tag", mem_tag[8'h12], 19'h5A5A5);
      do_refill(8'h13, 19'h00777, 1'b0);
      do_inv(8'h12, 19'h5A5A5);
      do_refill(8'h12, 19'h5A5A5, 1'b0);
      do_inv(8'h12, 19'h00001);
      mem_compare("directed_contents");

      // Random refill / invalidate mix over a small index window.
      for (int k = 0; k < 40; k++) begin
         a = IW'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0:       do_refill(a, TW'($urandom), 1'b0);
            1:       do_inv(a, sh_tag[a]);
            default: do_inv(a, TW'($urandom));
         endcase
      end
      mem_compare("random_contents");

      // Plain flush pulse, then every entry must read invalid.
      do_flush(1'b0);
      mem_compare("flush_contents");

      // Flush request held into the done cycle does not restart the sweep.
      do_refill(8'hFF, 19'h7FFFF, 1'b0);
      do_refill(8'h00, 19'h00001, 1'b0);
      do_flush(1'b1);
      mem_compare("flush_hold_contents");

      // All three requests together: flush, then invalidate, then refill.
      a = 8'h40;
      t = 19'h12345;
      flush_req   = 1'b1;
      inv_req     = 1'b1;
      inv_addr    = a;
      inv_tag     = t;
      refill_req  = 1'b1;
      refill_addr = a;
      refill_tag  = t;
      done_cyc = -1;
      inv_cyc  = -1;
      ref_cyc  = -1;
      wea_cnt  = 0;
      inv_hit_seen = 1'b0;
      cyc = 0;
      while (ref_cyc < 0 && cyc < 600) begin
         tick();
         cyc++;
         if (wea) wea_cnt++;
         if (flush_done) begin
            done_cyc  = cyc;
            flush_req = 1'b0;
         end
         if (inv_ack) begin
            inv_cyc      = cyc;
            inv_hit_seen = inv_hit;
            inv_req      = 1'b0;
         end
         if (refill_ack) begin
            ref_cyc    = cyc;
            refill_req = 1'b0;
         end
      end
      flush_req  = 1'b0;
      inv_req    = 1'b0;
      refill_req = 1'b0;
      check("combo_flush_done_cycle", done_cyc, 258);
      check("combo_inv_after_flush", inv_cyc, done_cyc + 2);
      check("combo_refill_after_inv", ref_cyc, inv_cyc + 1);
      check("combo_inv_miss", inv_hit_seen, 0);
      check("combo_write_count", wea_cnt, N + 1);
      for (int i = 0; i < N; i++) sh_valid[i] = 1'b0;
      sh_valid[a] = 1'b1;
      sh_tag[a]   = t;
      tick();
      mem_compare("combo_contents");

      // Reset during an invalidate: no ack, held request re-served afterwards.
      do_refill(8'h33, 19'h0ABCD, 1'b0);
      inv_addr = 8'h33;
      inv_tag  = 19'h0ABCD;
      inv_req  = 1'b1;
      tick();
      #1;
      resetn = 1'b0;
      #1;
      check("inv_reset_clears", {inv_ack, inv_hit, wea}, 0);
      check("inv_reset_addrc", addrc, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      lat = 0;
      while (!inv_ack && lat < 20) begin
         tick();
         lat++;
      end
      check("inv_reserve_latency", lat, 2);
      check("inv_reserve_hit", inv_hit, 1);
      sh_valid[8'h33] = 1'b0;
      inv_req = 1'b0;
      tick();

      // Reset during a flush at index 100.
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         tick();
         if (wea && addra == 8'd100) found = 1'b1;
      end
      check("flush_reached_100", found, 1);
      #1;
      resetn = 1'b0;
      #1;
      check("flush_reset_outputs", {wea, flush_busy, flush_done, dina_valid}, 0);
      check("flush_reset_addra", addra, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (wea || flush_busy || flush_done) seen++;
      end
      check("flush_reset_quiet", seen, 0);
      for (int i = 0; i < 100; i++) sh_valid[i] = 1'b0;
      mem_compare("flush_reset_contents");

      // Controller still serves normally after the aborted sweep.
      do_refill(8'h80, 19'h2AAAA, 1'b0);
      do_inv(8'h80, 19'h2AAAA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
